// File: rtl/sdram_cmd_arbiter_pkg.sv
// SDRAM command encodings {cs_n,ras_n,cas_n,we_n} and arbiter state codes shared
// by the command arbiter and its helpers.
package sdram_cmd_arbiter_pkg;

  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_NOP  = 4'b0111;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ARBIT = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } state_t;

  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } chan_t;

endpackage

// File: rtl/sdram_cmd_arbiter_watchdog.sv
// Refresh-latency watchdog: counts cycles a refresh request waits unserved and
// raises a sticky late flag once the wait reaches REF_TIMEOUT.
module sdram_ref_watchdog #(
  parameter int REF_TIMEOUT = 300,
  parameter int TO_W        = 9
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pending,
  output logic o_late
);

  localparam logic [TO_W-1:0] LP_LIMIT = TO_W'(REF_TIMEOUT);

  logic [TO_W-1:0] r_cnt;
  logic [TO_W-1:0] w_cnt_nxt;
  logic            r_late;

  // Any cycle without a pending refresh restarts the wait from zero.
  always_comb begin
    w_cnt_nxt = '0;
    if (i_pending) begin
      w_cnt_nxt = (r_cnt == LP_LIMIT) ? r_cnt : r_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_late <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == LP_LIMIT) begin
        r_late <= 1'b1;
      end
    end
  end

  assign o_late = r_late;

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Single-bus SDRAM command arbiter: init, refresh, write and read engines share
// the pins; refresh wins, write/read alternate on contention.
module sdram_cmd_arbiter
  import sdram_cmd_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int BA_W        = 2,
  parameter int DQ_W        = 16,
  parameter int REF_TIMEOUT = 300,
  parameter int TO_W        = 9
) (
  input  logic              sclk,
  input  logic              snrst,
  input  logic              init_done,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  output logic              aref_en,
  input  logic              aref_done,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  output logic              wr_en,
  output logic              wr_break,
  input  logic              wr_done,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [DQ_W-1:0]   wr_dq,
  input  logic              wr_dq_oe,
  input  logic              rd_req,
  output logic              rd_en,
  output logic              rd_break,
  input  logic              rd_done,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_ba,
  output logic              cs_n,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [ADDR_W-1:0] addr,
  output logic [BA_W-1:0]   ba,
  output logic [DQ_W-1:0]   dq_out,
  output logic              dq_oe,
  output logic              ref_late
);

  state_t r_state, w_state_nxt;
  chan_t  r_last_grant;
  logic   w_aref_gnt, w_wr_gnt, w_rd_gnt;
  logic   r_aref_en, r_wr_en, r_rd_en, r_wr_break, r_rd_break;
  logic [3:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr;
  logic [BA_W-1:0]   w_ba;

  always_comb begin
    w_state_nxt = r_state;
    w_aref_gnt  = 1'b0;
    w_wr_gnt    = 1'b0;
    w_rd_gnt    = 1'b0;
    case (r_state)
      ST_IDLE:  if (init_done) w_state_nxt = ST_ARBIT;
      // Refresh first; on a write/read tie the channel not served last wins.
      ST_ARBIT: begin
        if (aref_req) begin
          w_state_nxt = ST_AREF;
          w_aref_gnt  = 1'b1;
        end else if (wr_req && (!rd_req || r_last_grant == GNT_READ)) begin
          w_state_nxt = ST_WRITE;
          w_wr_gnt    = 1'b1;
        end else if (rd_req) begin
          w_state_nxt = ST_READ;
          w_rd_gnt    = 1'b1;
        end
      end
      ST_AREF:  if (aref_done) w_state_nxt = ST_ARBIT;
      ST_WRITE: if (wr_done) w_state_nxt = ST_ARBIT;
      ST_READ:  if (rd_done) w_state_nxt = ST_ARBIT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge snrst) begin
    if (!snrst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GNT_READ;
      r_aref_en    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_wr_break   <= 1'b0;
      r_rd_break   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_aref_en <= w_aref_gnt;
      r_wr_en   <= w_wr_gnt;
      r_rd_en   <= w_rd_gnt;
      if (w_wr_gnt) begin
        r_last_grant <= GNT_WRITE;
      end else if (w_rd_gnt) begin
        r_last_grant <= GNT_READ;
      end
      // Break latches on a refresh request and drops as the burst owner leaves.
      r_wr_break <= (w_state_nxt == ST_WRITE) && (r_wr_break || aref_req);
      r_rd_break <= (w_state_nxt == ST_READ)  && (r_rd_break || aref_req);
    end
  end

  always_comb begin
    w_cmd  = CMD_NOP;
    w_addr = '0;
    w_ba   = '0;
    case (r_state)
      ST_IDLE:  begin w_cmd = init_cmd; w_addr = init_addr; end
      ST_AREF:  begin w_cmd = aref_cmd; w_addr = aref_addr; end
      ST_WRITE: begin w_cmd = wr_cmd;   w_addr = wr_addr;   w_ba = wr_ba; end
      ST_READ:  begin w_cmd = rd_cmd;   w_addr = rd_addr;   w_ba = rd_ba; end
      default:  ;
    endcase
  end

  sdram_ref_watchdog #(
    .REF_TIMEOUT (REF_TIMEOUT),
    .TO_W        (TO_W)
  ) u_watchdog (
    .i_clk     (sclk),
    .i_rst_n   (snrst),
    .i_pending (aref_req && (r_state != ST_AREF)),
    .o_late    (ref_late)
  );

  assign {cs_n, ras_n, cas_n, we_n} = w_cmd;
  assign addr     = w_addr;
  assign ba       = w_ba;
  assign dq_out   = wr_dq;
  assign dq_oe    = (r_state == ST_WRITE) && wr_dq_oe;
  assign aref_en  = r_aref_en;
  assign wr_en    = r_wr_en;
  assign rd_en    = r_rd_en;
  assign wr_break = r_wr_break;
  assign rd_break = r_rd_break;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter: a bus-ownership model is checked every
// cycle, plus hand-computed checkpoints along the scenario.
module tb_sdram_cmd_arbiter;

  localparam int ADDR_W = 13, BA_W = 2, DQ_W = 16, REF_TIMEOUT = 300, TO_W = 9;

  logic sclk = 1'b0, snrst = 1'b0;
  logic init_done = 0, aref_req = 0, aref_done = 0, wr_req = 0, wr_done = 0;
  logic rd_req = 0, rd_done = 0, wr_dq_oe = 0;
  logic [3:0] init_cmd = 4'b0010, aref_cmd = 4'b0001, wr_cmd = 4'b0100, rd_cmd = 4'b0101;
  logic [ADDR_W-1:0] init_addr = 13'h0400, aref_addr = 13'h0000;
  logic [ADDR_W-1:0] wr_addr = 13'h0123, rd_addr = 13'h1456;
  logic [BA_W-1:0]   wr_ba = 2'b01, rd_ba = 2'b10;
  logic [DQ_W-1:0]   wr_dq = 16'hBEEF;
  logic aref_en, wr_en, wr_break, rd_en, rd_break;
  logic cs_n, ras_n, cas_n, we_n, dq_oe, ref_late;
  logic [ADDR_W-1:0] addr;
  logic [BA_W-1:0]   ba;
  logic [DQ_W-1:0]   dq_out;

  sdram_cmd_arbiter #(
    .ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W), .REF_TIMEOUT(REF_TIMEOUT), .TO_W(TO_W)
  ) dut (
    .sclk(sclk), .snrst(snrst), .init_done(init_done), .init_cmd(init_cmd),
    .init_addr(init_addr), .aref_req(aref_req), .aref_en(aref_en),
    .aref_done(aref_done), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_en(wr_en), .wr_break(wr_break), .wr_done(wr_done),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba), .wr_dq(wr_dq),
    .wr_dq_oe(wr_dq_oe), .rd_req(rd_req), .rd_en(rd_en), .rd_break(rd_break),
    .rd_done(rd_done), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
    .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .addr(addr), .ba(ba),
    .dq_out(dq_out), .dq_oe(dq_oe), .ref_late(ref_late)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0, n_bad = 0;
  string grants = "";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, which channel went last, pending pulses/breaks, wait length.
  typedef enum int {M_IDLE, M_ARB, M_REF, M_WR, M_RD} own_t;
  own_t m_own;
  logic m_last_wr, m_aref_en, m_wr_en, m_rd_en, m_wbrk, m_rbrk, m_late;
  int   m_wait, m_wnext;

  always @(posedge sclk or negedge snrst) begin
    if (!snrst) begin
      m_own <= M_IDLE; m_last_wr <= 1'b0; m_late <= 1'b0; m_wait <= 0;
      m_aref_en <= 0; m_wr_en <= 0; m_rd_en <= 0; m_wbrk <= 0; m_rbrk <= 0;
    end else begin
      m_aref_en <= 0; m_wr_en <= 0; m_rd_en <= 0;
      case (m_own)
        M_IDLE: if (init_done) m_own <= M_ARB;
        M_ARB:
          if (aref_req) begin m_own <= M_REF; m_aref_en <= 1; end
          else if (wr_req && rd_req) begin
            if (m_last_wr) begin m_own <= M_RD; m_rd_en <= 1; m_last_wr <= 0; end
            else begin m_own <= M_WR; m_wr_en <= 1; m_last_wr <= 1; end
          end
          else if (wr_req) begin m_own <= M_WR; m_wr_en <= 1; m_last_wr <= 1; end
          else if (rd_req) begin m_own <= M_RD; m_rd_en <= 1; m_last_wr <= 0; end
        M_REF: if (aref_done) m_own <= M_ARB;
        M_WR: if (wr_done) begin m_own <= M_ARB; m_wbrk <= 0; end
              else if (aref_req) m_wbrk <= 1;
        M_RD: if (rd_done) begin m_own <= M_ARB; m_rbrk <= 0; end
              else if (aref_req) m_rbrk <= 1;
        default: m_own <= M_IDLE;
      endcase
      m_wnext = (aref_req && m_own != M_REF) ? m_wait + 1 : 0;
      if (m_wnext > REF_TIMEOUT) m_wnext = REF_TIMEOUT;
      m_wait <= m_wnext;
      if (m_wnext == REF_TIMEOUT) m_late <= 1;
    end
  end

  function automatic logic [63:0] model_vec();
    logic [3:0] c; logic [ADDR_W-1:0] a; logic [BA_W-1:0] b; logic oe;
    c = 4'b0111; a = '0; b = '0; oe = 1'b0;
    case (m_own)
      M_IDLE: begin c = init_cmd; a = init_addr; end
      M_REF:  begin c = aref_cmd; a = aref_addr; end
      M_WR:   begin c = wr_cmd; a = wr_addr; b = wr_ba; oe = wr_dq_oe; end
      M_RD:   begin c = rd_cmd; a = rd_addr; b = rd_ba; end
      default: ;
    endcase
    return 64'({m_aref_en, m_wr_en, m_rd_en, m_wbrk, m_rbrk, m_late, oe, c, a, b, wr_dq});
  endfunction

  function automatic logic [63:0] dut_vec();
    return 64'({aref_en, wr_en, rd_en, wr_break, rd_break, ref_late, dq_oe,
                cs_n, ras_n, cas_n, we_n, addr, ba, dq_out});
  endfunction

  always @(negedge sclk) begin
    check("cycle", dut_vec(), model_vec());
    if (wr_en)   grants = {grants, "W"};
    if (rd_en)   grants = {grants, "R"};
    if (aref_en) grants = {grants, "A"};
  end

  task automatic step(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  initial begin
    step(3);
    check("reset_grants", {aref_en, wr_en, rd_en, wr_break, rd_break, ref_late}, 6'b0);
    snrst = 1'b1;
    step(10);
    check("idle_cmd", {cs_n, ras_n, cas_n, we_n}, 4'b0010);
    check("idle_addr", addr, 13'h0400);
    init_cmd = 4'b0000;
    step(40);
    check("idle_cmd2", {cs_n, ras_n, cas_n, we_n}, 4'b0000);
    init_done = 1'b1;
    step(1);
    check("arbit_nop", {cs_n, ras_n, cas_n, we_n, addr, ba}, {4'b0111, 13'h0, 2'b0});

    // Contended write/read: alternate starting with write.
    wr_req = 1; rd_req = 1;
    step(1);
    check("tie1_wr_en", {wr_en, rd_en, ba}, {1'b1, 1'b0, 2'b01});
    step(1);
    check("tie1_pulse_end", wr_en, 1'b0);
    wr_done = 1; step(1); wr_done = 0;
    step(1);
    check("tie2_rd_en", {wr_en, rd_en, ba}, {1'b0, 1'b1, 2'b10});
    rd_done = 1; step(1); rd_done = 0;
    step(1);
    check("tie3_wr_en", {wr_en, rd_en, ba}, {1'b1, 1'b0, 2'b01});
    wr_req = 0; rd_req = 0;
    wr_done = 1; step(1); wr_done = 0;

    // Refresh arrives two cycles into a write.
    wr_req = 1; step(1); wr_req = 0;
    step(2);
    aref_req = 1;
    step(1);
    check("wr_break_set", wr_break, 1'b1);
    step(3);
    check("wr_break_hold", wr_break, 1'b1);
    wr_done = 1; step(1); wr_done = 0;
    check("wr_break_clear", {wr_break, aref_en}, 2'b00);
    step(1);
    check("aref_grant", aref_en, 1'b1);
    aref_req = 0;
    step(2);
    aref_done = 1; step(1); aref_done = 0;

    // Done and refresh request coincide.
    wr_req = 1; step(1); wr_req = 0;
    step(2);
    wr_done = 1; aref_req = 1;
    step(1);
    wr_done = 0;
    check("coinc_arbit", {wr_break, aref_en, cs_n, ras_n, cas_n, we_n}, 6'b00_0111);
    step(1);
    check("coinc_aref", aref_en, 1'b1);
    aref_req = 0;
    step(1);
    aref_done = 1; step(1); aref_done = 0;

    // Long read with refresh pending: watchdog fires after REF_TIMEOUT cycles.
    rd_req = 1; step(1); rd_req = 0;
    aref_req = 1;
    step(299);
    check("late_before", ref_late, 1'b0);
    step(1);
    check("late_at_300", ref_late, 1'b1);
    step(10);
    rd_done = 1; step(1); rd_done = 0;
    step(1);
    check("late_aref_en", aref_en, 1'b1);
    rd_done = 1; step(1); rd_done = 0;
    check("rd_done_in_aref", {cs_n, ras_n, cas_n, we_n}, 4'b0001);
    step(1);
    aref_req = 0; aref_done = 1; step(1); aref_done = 0;
    check("late_sticky", ref_late, 1'b1);

    // Asynchronous reset in the middle of a write burst.
    wr_req = 1; step(1); wr_req = 0;
    wr_dq_oe = 1; aref_req = 1;
    step(2);
    check("pre_rst_oe_brk", {dq_oe, wr_break}, 2'b11);
    #2 snrst = 0;
    #1;
    check("rst_async_ctrl", {aref_en, wr_en, rd_en, wr_break, rd_break, ref_late, dq_oe}, 7'b0);
    check("rst_async_pins", {cs_n, ras_n, cas_n, we_n, addr}, {4'b0000, 13'h0400});
    step(2);
    aref_req = 0; wr_dq_oe = 0; snrst = 1;
    step(3);
    check("post_rst_idle", {cs_n, ras_n, cas_n, we_n}, 4'b0111);

    n_cmp++;
    if (grants != "WRWWAWARAW") begin
      n_bad++;
      $display("FAIL grant_order: got %s expected WRWWAWARAW", grants);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
